pcu_error_handler: RTL and testbench
====================================

# pcu_error_handler

Receives the encoded `cpu_error` id from the CPU error detector and enforces it on the PCU side. On the first nonzero id it latches the code and faulting PC, halts the CPU, and streams a 5-byte error report over a valid/ready byte interface to the debug/UART path. It then holds the CPU stopped until the PCU issues an explicit clear, and keeps a saturating count of captured errors.

## Interface
- `REPORT_EN`, default 1: 1 enables report streaming; 0 goes directly from capture to wait-for-clear.
- `CNT_W`, default 8: width of `err_count`.

- `clk`  in  1  system clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `cpu_error`  in  4  error id: 0 none, 1 divide by zero, 2 memory access, 3 opcode; other values are captured verbatim.
- `pc`  in  32  PC of the instruction currently producing `cpu_error`.
- `err_clear`  in  1  single-cycle clear request from the PCU; honored only in WAIT_CLR.
- `rep_ready`  in  1  report sink ready.
- `cpu_stop`  out  1  halt request to the CPU.
- `err_code`  out  4  latched error id.
- `err_pc`  out  32  latched faulting PC.
- `err_count`  out  CNT_W  number of captures, saturating.
- `rep_valid`  out  1  report byte valid.
- `rep_data`  out  8  report byte.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Clock and reset: single clock `clk`. Reset is asynchronous and active-low on `rstn`.
- States: IDLE, REPORT, WAIT_CLR.
- IDLE:
  - `cpu_error` is sampled every edge.
  - If it is nonzero, the handler latches `err_code` <= `cpu_error` and `err_pc` <= `pc`, and increments `err_count` (holds at all ones).
  - It then goes to REPORT, or to WAIT_CLR if `REPORT_EN` = 0.
- REPORT:
  - `rep_valid` = 1 and `rep_data` = byte[idx], with a 3-bit idx starting at 0.
  - Byte 0 = {4'hE, `err_code`}. Bytes 1–4 = `err_pc`[31:24], [23:16], [15:8], [7:0].
  - On `rep_valid && rep_ready`, idx increments. The transfer with idx = 4 moves the state to WAIT_CLR and clears idx.
  - `rep_data` and `rep_valid` stay stable while `rep_ready` = 0.
  - `err_clear` is ignored in this state.
- WAIT_CLR: `err_clear` = 1 moves the state to IDLE.
- `cpu_error` is ignored outside IDLE. The latched code and PC are never overwritten until the next capture.
- `cpu_stop` = 1 in REPORT and WAIT_CLR; `busy` follows the same rule.
- `err_code`, `err_pc` and `err_count` keep their values through clear; only a new capture or reset changes them.
- After a clear, if `cpu_error` is still nonzero in IDLE, the handler captures again. It is the PCU's responsibility to redirect the PC before issuing the clear.

## Timing
- Reset (asynchronous, any state, including mid-REPORT): state = IDLE, idx = 0.
  - All outputs read 0: `cpu_stop`, `busy`, `rep_valid`, `rep_data`, `err_code`, `err_pc`, `err_count`.
  - A partially sent report is abandoned; nothing resumes after reset.
- All outputs are registered or decoded from state/idx only; there is no combinational path from inputs to outputs.
- Capture latency: error present at edge N means `cpu_stop` = 1, latched values visible and `rep_valid` = 1 from cycle N+1.
- Report: 5 bytes. With `rep_ready` held at 1, bytes transfer at edges N+1 through N+5, and WAIT_CLR is entered at edge N+5.
- Backpressure: each cycle with `rep_ready` = 0 stalls the report by exactly one cycle.
- Clear: `err_clear` at edge M in WAIT_CLR means `cpu_stop` = 0 from cycle M+1; the earliest re-capture is at edge M+1.
- Simultaneous `err_clear` and nonzero `cpu_error` in WAIT_CLR: the clear wins and the error is evaluated next cycle in IDLE.
- `err_count` saturation: at all ones a capture leaves it unchanged; the capture itself still happens.

## Test plan
- Reset with `rstn` = 0 mid-REPORT (after byte 2): all outputs go to 0 immediately, state is IDLE, and no `rep_valid` appears until a new error.
- `cpu_error` = 1, `pc` = 32'h0000_1A2C with `rep_ready` = 1:
  - `cpu_stop` rises the next cycle.
  - Bytes E1, 00, 00, 1A, 2C are sent on 5 consecutive cycles.
  - `busy` stays 1 until `err_clear`, and `cpu_stop` falls the cycle after `err_clear`.
- `cpu_error` = 2, `pc` = 32'hDEAD_BEEF, with `rep_ready` toggling 1,0,0,1,0,1,1,1:
  - The byte sequence is E2, DE, AD, BE, EF with no byte dropped or duplicated.
  - `rep_data` is stable during stalls.
- During REPORT, change `cpu_error` to 3 and pulse `err_clear`: both are ignored, `err_code` stays 2, and the report completes.
- `REPORT_EN` = 0, `cpu_error` = 3: `rep_valid` never rises; WAIT_CLR is entered directly, with `err_code` = 3 and `cpu_stop` = 1 one cycle after the error.
- `CNT_W` = 2, with 5 capture/clear cycles:
  - `err_count` reads 1, 2, 3, 3, 3.
  - On the second and later captures, `err_clear` is pulsed while `cpu_error` is still nonzero, and a re-capture occurs on the cycle after the clear.

Source files
------------

// File: rtl/pcu_err_if.sv
// Signal bundle between the PCU/CPU side and the error handler.
// master drives error/clear/ready; slave (the handler) drives status and report bytes.
interface pcu_err_if #(
   parameter int CNT_W = 8
) ();
   logic [3:0]       cpu_error;
   logic [31:0]      pc;
   logic             err_clear;
   logic             rep_ready;
   logic             cpu_stop;
   logic [3:0]       err_code;
   logic [31:0]      err_pc;
   logic [CNT_W-1:0] err_count;
   logic             rep_valid;
   logic [7:0]       rep_data;
   logic             busy;

   modport master (
      output cpu_error, pc, err_clear, rep_ready,
      input  cpu_stop, err_code, err_pc, err_count, rep_valid, rep_data, busy
   );

   modport slave (
      input  cpu_error, pc, err_clear, rep_ready,
      output cpu_stop, err_code, err_pc, err_count, rep_valid, rep_data, busy
   );
endinterface

// File: rtl/pcu_error_handler.sv
// Captures the first CPU error, halts the CPU, streams a 5-byte report
// ({E,code}, PC MSB..LSB) and waits for an explicit PCU clear.
module pcu_error_handler #(
   parameter bit REPORT_EN = 1'b1,
   parameter int CNT_W     = 8
) (
   input  logic       clk,
   input  logic       rstn,
   pcu_err_if.slave   bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_REPORT = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [3:0]       code_q, code_d;
   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       rep_data;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      code_d  = code_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.cpu_error != 4'd0) begin
               code_d  = bus.cpu_error;
               pc_d    = bus.pc;
               idx_d   = 3'd0;
               state_d = REPORT_EN ? S_REPORT : S_WAIT;
               if (cnt_q != {CNT_W{1'b1}}) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_REPORT: begin
            // rep_valid is always high here, so ready alone completes a transfer
            if (bus.rep_ready) begin
               if (idx_q == 3'd4) begin
                  idx_d   = 3'd0;
                  state_d = S_WAIT;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         S_WAIT: begin
            if (bus.err_clear) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         idx_q   <= 3'd0;
         code_q  <= 4'd0;
         pc_q    <= 32'd0;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         code_q  <= code_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Report byte is decoded from registered state only, so it holds through stalls.
   always_comb begin
      rep_data = 8'h00;
      if (state_q == S_REPORT) begin
         case (idx_q)
            3'd0:    rep_data = {4'hE, code_q};
            3'd1:    rep_data = pc_q[31:24];
            3'd2:    rep_data = pc_q[23:16];
            3'd3:    rep_data = pc_q[15:8];
            3'd4:    rep_data = pc_q[7:0];
            default: rep_data = 8'h00;
         endcase
      end
   end

   assign bus.cpu_stop  = (state_q != S_IDLE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.rep_valid = (state_q == S_REPORT);
   assign bus.rep_data  = rep_data;
   assign bus.err_code  = code_q;
   assign bus.err_pc    = pc_q;
   assign bus.err_count = cnt_q;
endmodule

// File: tb/tb_pcu_error_handler.sv
// Bench for pcu_error_handler: directed sequences, a vector table and a
// randomized run against a queue-based reference model.
module tb_pcu_error_handler;
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   pcu_err_if #(.CNT_W(8)) bm ();
   pcu_err_if #(.CNT_W(8)) bn ();
   pcu_err_if #(.CNT_W(2)) bc ();

   pcu_error_handler #(.REPORT_EN(1'b1), .CNT_W(8)) dut_main (.clk(clk), .rstn(rstn), .bus(bm));
   pcu_error_handler #(.REPORT_EN(1'b0), .CNT_W(8)) dut_norep (.clk(clk), .rstn(rstn), .bus(bn));
   pcu_error_handler #(.REPORT_EN(1'b1), .CNT_W(2)) dut_cnt2 (.clk(clk), .rstn(rstn), .bus(bc));

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic [3:0]  err;
      logic [31:0] pc;
      logic        clr;
      logic        rdy;
      logic        stop;
      logic        valid;
      logic [7:0]  data;
      logic [3:0]  code;
   } vec_t;
   vec_t tbl[12];

   // Reference model: a queue of bytes still owed to the sink plus a waiting-for-clear flag.
   logic [7:0]  mq[$];
   logic        m_wait;
   logic [3:0]  m_code;
   logic [31:0] m_pc;
   int          m_cnt;

   task automatic model_step(input logic [3:0] e, input logic [31:0] p, input logic c, input logic r);
      if (mq.size() == 0 && !m_wait) begin
         if (e != 4'd0) begin
            m_code = e;
            m_pc   = p;
            if (m_cnt < 255) m_cnt++;
            mq.push_back({4'hE, e});
            for (int b = 3; b >= 0; b--) mq.push_back(p[8*b +: 8]);
         end
      end else if (mq.size() != 0) begin
         if (r) begin
            mq.delete(0);
            if (mq.size() == 0) m_wait = 1'b1;
         end
      end else if (c) begin
         m_wait = 1'b0;
      end
   endtask

   initial begin
      logic [7:0] bytes1[5];
      int         exp_cnt[5];
      bytes1  = '{8'hE1, 8'h00, 8'h00, 8'h1A, 8'h2C};
      exp_cnt = '{1, 2, 3, 3, 3};

      tbl[0]  = '{4'd2, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd1};
      tbl[1]  = '{4'd0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 8'hE2, 4'd2};
      tbl[2]  = '{4'd3, 32'h11111111, 1'b1, 1'b0, 1'b1, 1'b1, 8'hDE, 4'd2};
      tbl[3]  = '{4'd3, 32'h22222222, 1'b1, 1'b0, 1'b1, 1'b1, 8'hDE, 4'd2};
      tbl[4]  = '{4'd0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 8'hDE, 4'd2};
      tbl[5]  = '{4'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'hAD, 4'd2};
      tbl[6]  = '{4'd0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 8'hAD, 4'd2};
      tbl[7]  = '{4'd0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 8'hBE, 4'd2};
      tbl[8]  = '{4'd0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 8'hEF, 4'd2};
      tbl[9]  = '{4'd5, 32'h33333333, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd2};
      tbl[10] = '{4'd4, 32'h44444444, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd2};
      tbl[11] = '{4'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd2};

      bm.cpu_error = 4'd0; bm.pc = 32'd0; bm.err_clear = 1'b0; bm.rep_ready = 1'b0;
      bn.cpu_error = 4'd0; bn.pc = 32'd0; bn.err_clear = 1'b0; bn.rep_ready = 1'b0;
      bc.cpu_error = 4'd0; bc.pc = 32'd0; bc.err_clear = 1'b0; bc.rep_ready = 1'b0;
      repeat (3) step();
      rstn = 1'b1;

      chk("reset_stop",  bm.cpu_stop, 0);
      chk("reset_busy",  bm.busy, 0);
      chk("reset_valid", bm.rep_valid, 0);
      chk("reset_data",  bm.rep_data, 0);
      chk("reset_code",  bm.err_code, 0);
      chk("reset_pc",    bm.err_pc, 0);
      chk("reset_count", bm.err_count, 0);

      // Divide-by-zero capture with the sink always ready
      bm.cpu_error = 4'd1; bm.pc = 32'h0000_1A2C; bm.rep_ready = 1'b1;
      chk("t1_stop_pre", bm.cpu_stop, 0);
      step();
      bm.cpu_error = 4'd0;
      chk("t1_stop", bm.cpu_stop, 1);
      chk("t1_code", bm.err_code, 1);
      chk("t1_pc", bm.err_pc, 32'h0000_1A2C);
      chk("t1_count", bm.err_count, 1);
      for (int i = 0; i < 5; i++) begin
         chk("t1_valid", bm.rep_valid, 1);
         chk("t1_byte", bm.rep_data, bytes1[i]);
         step();
      end
      chk("t1_valid_done", bm.rep_valid, 0);
      repeat (3) begin
         chk("t1_busy_wait", bm.busy, 1);
         step();
      end
      bm.err_clear = 1'b1;
      step();
      bm.err_clear = 1'b0;
      chk("t1_stop_clr", bm.cpu_stop, 0);
      chk("t1_busy_clr", bm.busy, 0);

      // Backpressure table, with ignored error/clear during REPORT and clear-wins in WAIT_CLR
      for (int i = 0; i < 12; i++) begin
         bm.cpu_error = tbl[i].err; bm.pc = tbl[i].pc;
         bm.err_clear = tbl[i].clr; bm.rep_ready = tbl[i].rdy;
         chk($sformatf("tbl%0d_stop", i), bm.cpu_stop, tbl[i].stop);
         chk($sformatf("tbl%0d_valid", i), bm.rep_valid, tbl[i].valid);
         if (tbl[i].valid) chk($sformatf("tbl%0d_data", i), bm.rep_data, tbl[i].data);
         chk($sformatf("tbl%0d_code", i), bm.err_code, tbl[i].code);
         step();
      end
      chk("tbl_pc_kept", bm.err_pc, 32'hDEADBEEF);
      bm.cpu_error = 4'd0; bm.err_clear = 1'b0; bm.rep_ready = 1'b0;

      // Reporting disabled: capture goes straight to wait-for-clear
      bn.cpu_error = 4'd3; bn.pc = 32'hCAFE_0004;
      chk("nr_stop_pre", bn.cpu_stop, 0);
      step();
      bn.cpu_error = 4'd0;
      chk("nr_stop", bn.cpu_stop, 1);
      chk("nr_code", bn.err_code, 3);
      chk("nr_pc", bn.err_pc, 32'hCAFE_0004);
      repeat (4) begin
         chk("nr_valid", bn.rep_valid, 0);
         chk("nr_hold", bn.cpu_stop, 1);
         step();
      end
      bn.err_clear = 1'b1;
      step();
      bn.err_clear = 1'b0;
      chk("nr_stop_clr", bn.cpu_stop, 0);

      // Two-bit counter saturation with clear issued while the error persists
      bc.cpu_error = 4'd1; bc.pc = 32'h0000_0100; bc.rep_ready = 1'b1;
      step();
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("c2_count%0d", k), bc.err_count, exp_cnt[k]);
         chk($sformatf("c2_stop%0d", k), bc.cpu_stop, 1);
         repeat (5) step();
         chk($sformatf("c2_wait_valid%0d", k), bc.rep_valid, 0);
         chk($sformatf("c2_wait_stop%0d", k), bc.cpu_stop, 1);
         if (k < 4) begin
            bc.err_clear = 1'b1;
            step();
            bc.err_clear = 1'b0;
            chk($sformatf("c2_idle%0d", k), bc.cpu_stop, 0);
            step();
         end
      end
      bc.cpu_error = 4'd0; bc.err_clear = 1'b1;
      step();
      bc.err_clear = 1'b0;
      chk("c2_final_idle", bc.busy, 0);

      // Asynchronous reset after byte 2 of a report
      bm.cpu_error = 4'd7; bm.pc = 32'h1234_5678; bm.rep_ready = 1'b1;
      step();
      bm.cpu_error = 4'd0;
      repeat (3) step();
      chk("rst_mid_byte3", bm.rep_data, 8'h56);
      #2 rstn = 1'b0;
      #1;
      chk("rst_stop",  bm.cpu_stop, 0);
      chk("rst_busy",  bm.busy, 0);
      chk("rst_valid", bm.rep_valid, 0);
      chk("rst_data",  bm.rep_data, 0);
      chk("rst_code",  bm.err_code, 0);
      chk("rst_pc",    bm.err_pc, 0);
      chk("rst_count", bm.err_count, 0);
      step();
      rstn = 1'b1;
      repeat (5) begin
         chk("rst_no_valid", bm.rep_valid, 0);
         step();
      end

      // Randomized run against the reference model
      mq.delete();
      m_wait = 1'b0; m_code = 4'd0; m_pc = 32'd0; m_cnt = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bm.cpu_error = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
         bm.pc        = $urandom;
         bm.err_clear = ($urandom_range(0, 2) == 0);
         bm.rep_ready = ($urandom_range(0, 1) == 0);
         chk("rnd_stop",  bm.cpu_stop, (mq.size() != 0) || m_wait);
         chk("rnd_busy",  bm.busy, (mq.size() != 0) || m_wait);
         chk("rnd_valid", bm.rep_valid, mq.size() != 0);
         if (mq.size() != 0) chk("rnd_data", bm.rep_data, mq[0]);
         chk("rnd_code",  bm.err_code, m_code);
         chk("rnd_pc",    bm.err_pc, m_pc);
         chk("rnd_count", bm.err_count, m_cnt);
         model_step(bm.cpu_error, bm.pc, bm.err_clear, bm.rep_ready);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
